// File: rtl/bpred_update_unit.sv
// Branch-predictor update unit: resolves branches from execute, queues predictor updates in a
// FIFO drained when the predictor is not stalled, and pulses a fetch redirect on mispredicts.
// Optional statistics counters are enabled with `define BPRED_UPD_STATS_EN.
module bpred_update_unit #(
  parameter int QDEPTH = 4,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [31:0]       ex_PC4,
  input  logic              ex_actual_dir,
  input  logic [31:0]       ex_actual_target,
  input  logic              ex_pred_dir,
  input  logic [31:0]       ex_pred_target,
  input  logic [11:0]       ex_bimodal,
  input  logic [8:0]        ex_bit_carry,
  input  logic              soin_bpredictor_stall,
  output logic              execute_bpredictor_update,
  output logic [31:0]       execute_bpredictor_PC4,
  output logic [31:0]       execute_bpredictor_target,
  output logic              execute_bpredictor_dir,
  output logic              execute_bpredictor_miss,
  output logic [11:0]       execute_bpredictor_bimodal,
  output logic [29:0]       up_btb_data,
  output logic [8:0]        up_carry_data,
  output logic [3:0]        byte_en,
`ifdef BPRED_UPD_STATS_EN
  input  logic [1:0]        stat_sel,
  output logic [CNT_W-1:0]  stat_data,
`endif
  output logic              redirect_valid,
  output logic [31:0]       redirect_pc
);
  localparam int PW = $clog2(QDEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(QDEPTH);

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] target;
    logic        dir;
    logic        miss;
    logic [11:0] bimodal;
    logic [8:0]  carry;
    logic [3:0]  be;
  } entry_t;

  entry_t          mem [QDEPTH];
  entry_t          head, new_e;
  logic [PW-1:0]   wr_ptr, rd_ptr, rd_next;
  logic [PW:0]     count, cnt_next;
  logic            push, pop, tgt_diff;

  always_comb begin
    tgt_diff      = ex_pred_target != ex_actual_target;
    new_e.pc4     = ex_PC4;
    new_e.target  = ex_actual_target;
    new_e.dir     = ex_actual_dir;
    new_e.miss    = (ex_pred_dir != ex_actual_dir) | (ex_actual_dir & ex_pred_dir & tgt_diff);
    new_e.bimodal = ex_bimodal;
    new_e.carry   = ex_bit_carry;
    new_e.be      = (ex_actual_dir & tgt_diff) ? 4'b1111 : 4'b0001;
  end

  assign ex_ready = (count != FULL);
  assign push     = ex_valid & ex_ready;
  assign pop      = (count != '0) & ~soin_bpredictor_stall;
  assign rd_next  = rd_ptr + PW'(pop);
  assign cnt_next = count + (PW+1)'(push) - (PW+1)'(pop);

  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= new_e;

  // head is a register copy of the next FIFO head; it holds its last value while empty
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      head           <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr <= rd_next;
      count  <= cnt_next;
      if (cnt_next != '0)
        head <= (push && (wr_ptr == rd_next)) ? new_e : mem[rd_next];
      redirect_valid <= push & new_e.miss;
      if (push & new_e.miss)
        redirect_pc <= ex_actual_dir ? ex_actual_target : ex_PC4;
    end
  end

  assign execute_bpredictor_update  = (count != '0);
  assign execute_bpredictor_PC4     = head.pc4;
  assign execute_bpredictor_target  = head.target;
  assign execute_bpredictor_dir     = head.dir;
  assign execute_bpredictor_miss    = head.miss;
  assign execute_bpredictor_bimodal = head.bimodal;
  assign up_btb_data                = head.target[31:2];
  assign up_carry_data              = head.carry;
  assign byte_en                    = head.be;

`ifdef BPRED_UPD_STATS_EN
  logic [CNT_W-1:0] stat_cnt [4];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) stat_cnt[i] <= '0;
    end else begin
      if (push)                         stat_cnt[0] <= stat_cnt[0] + 1'b1;
      if (push & new_e.miss)            stat_cnt[1] <= stat_cnt[1] + 1'b1;
      if (push & (new_e.be == 4'b1111)) stat_cnt[2] <= stat_cnt[2] + 1'b1;
      if ((count != '0) & soin_bpredictor_stall)
                                        stat_cnt[3] <= stat_cnt[3] + 1'b1;
    end
  end

  assign stat_data = stat_cnt[stat_sel];
`endif

endmodule

// File: tb/tb_bpred_update_unit.sv
// Self-checking bench for bpred_update_unit: directed vector table, multi-cycle corner
// sequences and randomized traffic against a queue-based reference model.
module tb_bpred_update_unit;
  logic        clk = 1'b0, reset = 1'b1;
  logic        ex_valid = 1'b0, ex_ready;
  logic [31:0] ex_PC4 = '0, ex_actual_target = '0, ex_pred_target = '0;
  logic        ex_actual_dir = 1'b0, ex_pred_dir = 1'b0;
  logic [11:0] ex_bimodal = '0;
  logic [8:0]  ex_bit_carry = '0;
  logic        stall = 1'b0;
  logic        update, dir, miss, redirect_valid;
  logic [31:0] pc4_o, target_o, redirect_pc;
  logic [11:0] bimodal_o;
  logic [29:0] btb_o;
  logic [8:0]  carry_o;
  logic [3:0]  byte_en;
`ifdef BPRED_UPD_STATS_EN
  logic [1:0]  stat_sel = '0;
  logic [31:0] stat_data;
`endif

  bpred_update_unit #(.QDEPTH(4), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_PC4(ex_PC4), .ex_actual_dir(ex_actual_dir), .ex_actual_target(ex_actual_target),
    .ex_pred_dir(ex_pred_dir), .ex_pred_target(ex_pred_target), .ex_bimodal(ex_bimodal),
    .ex_bit_carry(ex_bit_carry), .soin_bpredictor_stall(stall),
    .execute_bpredictor_update(update), .execute_bpredictor_PC4(pc4_o),
    .execute_bpredictor_target(target_o), .execute_bpredictor_dir(dir),
    .execute_bpredictor_miss(miss), .execute_bpredictor_bimodal(bimodal_o),
    .up_btb_data(btb_o), .up_carry_data(carry_o), .byte_en(byte_en),
`ifdef BPRED_UPD_STATS_EN
    .stat_sel(stat_sel), .stat_data(stat_data),
`endif
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc4, at, pt;
    logic        ad, pd;
    logic [11:0] bim;
    logic [8:0]  carry;
  } in_t;

  typedef struct {
    logic [31:0] pc4, tgt;
    logic        dir, miss;
    logic [11:0] bim;
    logic [8:0]  carry;
    logic [3:0]  be;
  } m_entry_t;

  typedef struct {
    in_t         in;
    logic        exp_miss;
    logic [3:0]  exp_be;
    logic [31:0] exp_rpc;
  } vec_t;

  int checks = 0, failures = 0;
  m_entry_t q[$];
  m_entry_t last_head;
  logic        exp_rv;
  logic [31:0] exp_rpc;
  int acc_cnt, miss_cnt, btb_cnt, stall_cnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference rules: a taken branch is correct only if direction and target both match;
  // a not-taken branch is wrong exactly when taken was predicted.
  function automatic m_entry_t model(input in_t i);
    m_entry_t e;
    e.pc4 = i.pc4; e.tgt = i.at; e.dir = i.ad; e.bim = i.bim; e.carry = i.carry;
    e.miss = i.ad ? !(i.pd && i.pt == i.at) : i.pd;
    e.be = (i.ad && i.pt != i.at) ? 4'b1111 : 4'b0001;
    return e;
  endfunction

  task automatic model_reset();
    q.delete();
    last_head = '{default: '0};
    exp_rv = 1'b0; exp_rpc = '0;
    acc_cnt = 0; miss_cnt = 0; btb_cnt = 0; stall_cnt = 0;
  endtask

  // Called at a negedge: drive inputs, advance one clock, land on the next negedge.
  task automatic step(input logic v, input logic s, input in_t i);
    m_entry_t e;
    bit acc, pp;
    ex_valid = v; stall = s;
    ex_PC4 = i.pc4; ex_actual_target = i.at; ex_actual_dir = i.ad;
    ex_pred_dir = i.pd; ex_pred_target = i.pt; ex_bimodal = i.bim; ex_bit_carry = i.carry;
    e = model(i);
    acc = v && (q.size() != 4);
    pp = (q.size() != 0) && !s;
    @(posedge clk);
    if (q.size() != 0 && s) stall_cnt++;
    if (pp) void'(q.pop_front());
    if (acc) begin
      q.push_back(e);
      acc_cnt++;
      if (e.miss) miss_cnt++;
      if (e.be == 4'b1111) btb_cnt++;
    end
    exp_rv = acc && e.miss;
    if (acc && e.miss) exp_rpc = i.ad ? i.at : i.pc4;
    if (q.size() != 0) last_head = q[0];
    @(negedge clk);
  endtask

  task automatic check_all(input string tag);
    m_entry_t h;
    h = (q.size() != 0) ? q[0] : last_head;
    check({tag, ".update"}, update, q.size() != 0);
    check({tag, ".ex_ready"}, ex_ready, q.size() != 4);
    check({tag, ".redirect_valid"}, redirect_valid, exp_rv);
    check({tag, ".redirect_pc"}, redirect_pc, exp_rpc);
    check({tag, ".pc4"}, pc4_o, h.pc4);
    check({tag, ".target"}, target_o, h.tgt);
    check({tag, ".dir"}, dir, h.dir);
    check({tag, ".miss"}, miss, h.miss);
    check({tag, ".bimodal"}, bimodal_o, h.bim);
    check({tag, ".btb_data"}, btb_o, h.tgt >> 2);
    check({tag, ".carry"}, carry_o, h.carry);
    check({tag, ".byte_en"}, byte_en, h.be);
  endtask

  function automatic in_t mk(input logic [31:0] pc4, input logic [31:0] at, input logic ad,
                             input logic pd, input logic [31:0] pt);
    in_t i;
    i.pc4 = pc4; i.at = at; i.ad = ad; i.pd = pd; i.pt = pt;
    i.bim = 12'h5A0 ^ pc4[11:0]; i.carry = 9'h1C3 ^ at[8:0];
    return i;
  endfunction

  function automatic in_t rnd_in();
    in_t i;
    i.pc4 = $urandom & 32'hFFFF_FFFC;
    i.at  = $urandom & 32'hFFFF_FFFC;
    i.ad  = 1'($urandom);
    i.pd  = 1'($urandom);
    i.pt  = ($urandom_range(0, 1) == 1) ? i.at : ($urandom & 32'hFFFF_FFFC);
    i.bim = 12'($urandom);
    i.carry = 9'($urandom);
    return i;
  endfunction

  vec_t vecs[6];
  in_t  idle;

  initial begin
    idle = mk(0, 0, 0, 0, 0);
    vecs[0] = '{mk(32'h104, 32'h200, 1, 1, 32'h200), 1'b0, 4'b0001, 32'h0};
    vecs[1] = '{mk(32'h104, 32'h300, 1, 0, 32'h200), 1'b1, 4'b1111, 32'h300};
    vecs[2] = '{mk(32'h48,  32'h80,  0, 1, 32'h80),  1'b1, 4'b0001, 32'h48};
    vecs[3] = '{mk(32'h48,  32'h80,  0, 0, 32'h80),  1'b0, 4'b0001, 32'h0};
    vecs[4] = '{mk(32'h1000, 32'h2000, 1, 1, 32'h3000), 1'b1, 4'b1111, 32'h2000};
    vecs[5] = '{mk(32'h1000, 32'h2000, 1, 0, 32'h2000), 1'b1, 4'b0001, 32'h2000};

    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    reset = 1'b0;
    @(negedge clk);

    // Directed vectors, each pushed into an empty FIFO with no stall
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 1'b0, vecs[k].in);
      check($sformatf("vec%0d.update", k), update, 1'b1);
      check($sformatf("vec%0d.miss", k), miss, vecs[k].exp_miss);
      check($sformatf("vec%0d.byte_en", k), byte_en, vecs[k].exp_be);
      check($sformatf("vec%0d.btb", k), btb_o, vecs[k].in.at[31:2]);
      check($sformatf("vec%0d.rv", k), redirect_valid, vecs[k].exp_miss);
      if (vecs[k].exp_miss) check($sformatf("vec%0d.rpc", k), redirect_pc, vecs[k].exp_rpc);
      check_all($sformatf("vec%0d", k));
      step(1'b0, 1'b0, idle);
      check($sformatf("vec%0d.rv_off", k), redirect_valid, 1'b0);
      check($sformatf("vec%0d.empty", k), update, 1'b0);
      check($sformatf("vec%0d.hold_miss", k), miss, vecs[k].exp_miss);
      check_all($sformatf("vec%0d.after", k));
    end
    check("vec1.btb_c0", {2'b00, vecs[1].in.at[31:2]}, 32'hC0);
`ifdef BPRED_UPD_STATS_EN
    stat_sel = 2'd1; #1;
    check("stat.miss_after_vecs", stat_data, 32'd4);
`endif

    // Fill under stall: 4 accepted, 5th refused; drain in order
    for (int k = 0; k < 5; k++) begin
      check($sformatf("fill%0d.ex_ready", k), ex_ready, k < 4);
      step(1'b1, 1'b1, mk(32'h400 + 32'(k) * 4, 32'h800 + 32'(k) * 16, 1, 0, 0));
      check_all($sformatf("fill%0d", k));
    end
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b0, idle);
      if (k < 3) check($sformatf("drain%0d.pc4", k), pc4_o, 32'h404 + 32'(k) * 4);
      check($sformatf("drain%0d.ex_ready", k), ex_ready, 1'b1);
      check_all($sformatf("drain%0d", k));
    end
    check("drain.empty", update, 1'b0);

    // Full with pop, then push and pop together at count 3
    for (int k = 0; k < 4; k++) step(1'b1, 1'b1, mk(32'h900 + 32'(k) * 4, 32'hA00, 0, 0, 0));
    check("full.ex_ready", ex_ready, 1'b0);
    step(1'b1, 1'b0, mk(32'h9F0, 32'hB00, 1, 1, 32'hB00));
    check_all("full_pop");
    step(1'b1, 1'b0, mk(32'h9F4, 32'hB00, 1, 1, 32'hB00));
    check_all("pushpop");
    check("pushpop.pc4", pc4_o, 32'h908);

    // Reset mid-drain while a redirect pulse is live
    for (int k = 0; k < 2; k++) step(1'b1, 1'b1, mk(32'hC00 + 32'(k) * 4, 32'hD00, 0, 0, 0));
    step(1'b0, 1'b0, idle);
    step(1'b1, 1'b1, mk(32'hC08, 32'hE00, 1, 0, 32'h0));
    check("mid.rv_before", redirect_valid, 1'b1);
    reset = 1'b1; #1;
    model_reset();
    check_all("mid_reset_async");
    @(negedge clk);
    reset = 1'b0;
    check_all("mid_reset");
    step(1'b0, 1'b0, idle);
    check_all("post_reset");

    // Randomized traffic against the reference queue
    for (int c = 0; c < 400; c++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0), rnd_in());
      check_all($sformatf("rnd%0d", c));
    end

`ifdef BPRED_UPD_STATS_EN
    stat_sel = 2'd0; #1; check("stat.accepted", stat_data, 32'(acc_cnt));
    stat_sel = 2'd1; #1; check("stat.miss", stat_data, 32'(miss_cnt));
    stat_sel = 2'd2; #1; check("stat.btb", stat_data, 32'(btb_cnt));
    stat_sel = 2'd3; #1; check("stat.stall", stat_data, 32'(stall_cnt));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
